// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in/serial-out transmitter:
// FSM state encoding and the bit-index counter width helper.
package piso_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Bits needed to hold indices 0..n-1; never less than one bit.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/piso_shift_tx_if.sv
// Load handshake and serial-link signals of the transmitter.
// master = word producer / link observer, slave = the transmitter itself.
interface piso_shift_tx_if #(
    parameter int WIDTH = 4
);
    logic             shift_en;
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             ser_out;
    logic             ser_valid;
    logic             frame_start;
    logic             frame_end;
    logic             busy;

    modport master (
        output shift_en, load_valid, load_data,
        input  load_ready, ser_out, ser_valid, frame_start, frame_end, busy
    );

    modport slave (
        input  shift_en, load_valid, load_data,
        output load_ready, ser_out, ser_valid, frame_start, frame_end, busy
    );

endinterface

// File: rtl/piso_bit_counter.sv
// Index of the frame bit currently on the serial line.
// Clears on a word load, advances on enable, saturates at the last index.
module piso_bit_counter #(
    parameter int WIDTH = 4,
    parameter int CW    = 2
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          i_clear,
    input  logic          i_en,
    output logic [CW-1:0] o_cnt,
    output logic          o_tc
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!clr || i_clear) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == LAST);

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter: accepts a word on a valid/ready
// handshake and emits it one bit per enabled clock, with frame strobes.
module piso_shift_tx
    import piso_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic              clk,
    input  logic              clr,
    piso_shift_tx_if.slave    bus
);

    localparam int CW = clog2(WIDTH);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shreg_shifted;
    logic [CW-1:0]    w_cnt;
    logic             w_tc;
    logic             w_accept;
    logic             w_advance;
    logic             w_load_ready;
    logic             w_ser_out;
    logic             w_ser_valid;
    logic             w_frame_start;
    logic             w_frame_end;
    logic             w_busy;

    // Ready never looks at load_valid, so the producer may wait on it freely.
    assign w_load_ready = clr && ((r_state == ST_IDLE) || (w_tc && bus.shift_en));
    assign w_accept     = bus.load_valid && w_load_ready;
    assign w_advance    = (r_state == ST_SHIFT) && bus.shift_en && !w_tc;

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bus.shift_en && w_tc) begin
                    w_state_next = w_accept ? ST_SHIFT : ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_ser_valid   = (r_state == ST_SHIFT);
        w_busy        = (r_state == ST_SHIFT);
        w_ser_out     = IDLE_LEVEL;
        w_frame_start = 1'b0;
        w_frame_end   = 1'b0;
        if (r_state == ST_SHIFT) begin
            w_ser_out     = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
            w_frame_start = (w_cnt == '0);
            w_frame_end   = w_tc;
        end
    end

    // The outgoing bit always sits at the output end; shifting pulls zeros in behind it.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shreg_shifted = {r_shreg[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_shreg_shifted = {1'b0, r_shreg[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_shreg <= '0;
        end else if (w_accept) begin
            r_shreg <= bus.load_data;
        end else if (w_advance) begin
            r_shreg <= w_shreg_shifted;
        end
    end

    piso_bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_bit_counter (
        .clk     (clk),
        .clr     (clr),
        .i_clear (w_accept),
        .i_en    (w_advance),
        .o_cnt   (w_cnt),
        .o_tc    (w_tc)
    );

    assign bus.load_ready  = w_load_ready;
    assign bus.ser_out     = w_ser_out;
    assign bus.ser_valid   = w_ser_valid;
    assign bus.frame_start = w_frame_start;
    assign bus.frame_end   = w_frame_end;
    assign bus.busy        = w_busy;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Directed bench for piso_shift_tx: one MSB-first and one LSB-first instance,
// with a 4-bit serial-in receiver model fed from the MSB-first link.
module tb_piso_shift_tx;

    logic clk = 1'b0;
    logic clr = 1'b0;
    int   n_vec  = 0;
    int   n_miss = 0;
    logic [3:0] sipo_reg = 4'h0;

    always #5 clk = ~clk;

    piso_shift_tx_if #(.WIDTH(4)) if_msb ();
    piso_shift_tx_if #(.WIDTH(4)) if_lsb ();

    piso_shift_tx #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_msb (
        .clk (clk),
        .clr (clr),
        .bus (if_msb)
    );

    piso_shift_tx #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (
        .clk (clk),
        .clr (clr),
        .bus (if_lsb)
    );

    // Receiving 4-bit serial-in shift register: takes a bit on every enabled frame cycle.
    always @(posedge clk) begin
        if (if_msb.ser_valid && if_msb.shift_en) begin
            sipo_reg <= {sipo_reg[2:0], if_msb.ser_out};
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load one word into the MSB-first instance and follow the whole frame.
    task automatic run_frame(input string name, input logic [3:0] word);
        if_msb.load_valid = 1'b1;
        if_msb.load_data  = word;
        if_msb.shift_en   = 1'b1;
        #1;
        chk({name, "_ready"}, 32'(if_msb.load_ready), 32'd1);
        tick();
        if_msb.load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_bit%0d", name, i), 32'(if_msb.ser_out), 32'(word[3-i]));
            chk($sformatf("%s_sv%0d", name, i), 32'(if_msb.ser_valid), 32'd1);
            chk($sformatf("%s_fs%0d", name, i), 32'(if_msb.frame_start), 32'(i == 0));
            chk($sformatf("%s_fe%0d", name, i), 32'(if_msb.frame_end), 32'(i == 3));
            tick();
        end
        chk({name, "_idle_busy"}, 32'(if_msb.busy), 32'd0);
        chk({name, "_idle_sv"}, 32'(if_msb.ser_valid), 32'd0);
        $display("%s: word %b sent MSB first", name, word);
    endtask

    logic [5:0] stall_out;
    logic [5:0] stall_se;
    logic [7:0] b2b_bits;
    logic [3:0] lsb_word;

    initial begin
        if_msb.shift_en   = 1'b0;
        if_msb.load_valid = 1'b0;
        if_msb.load_data  = 4'h0;
        if_lsb.shift_en   = 1'b0;
        if_lsb.load_valid = 1'b0;
        if_lsb.load_data  = 4'h0;

        // T1 reset with load_valid asserted
        clr = 1'b0;
        if_msb.load_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rst_ready%0d", i), 32'(if_msb.load_ready), 32'd0);
            chk($sformatf("rst_sv%0d", i), 32'(if_msb.ser_valid), 32'd0);
            chk($sformatf("rst_so%0d", i), 32'(if_msb.ser_out), 32'd0);
        end
        if_msb.load_valid = 1'b0;
        clr = 1'b1;
        #1;
        chk("rst_release_ready", 32'(if_msb.load_ready), 32'd1);
        chk("rst_release_ready_lsb", 32'(if_lsb.load_ready), 32'd1);
        $display("T1: reset held 3 cycles, released");

        // T2 single word
        run_frame("T2", 4'b1011);

        // T3 loopback into the receiver, read one cycle after frame_end
        run_frame("T3", 4'b0011);
        chk("T3_sipo", 32'(sipo_reg), 32'h3);

        // T4 stall for two cycles while bit 1 is on the line
        stall_out = 6'b100001;   // index = cycle-1, word 1001
        stall_se  = 6'b111001;   // shift_en during each cycle
        if_msb.load_valid = 1'b1;
        if_msb.load_data  = 4'b1001;
        if_msb.shift_en   = 1'b1;
        tick();
        if_msb.load_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if_msb.shift_en = stall_se[c];
            chk($sformatf("T4_bit_c%0d", c + 1), 32'(if_msb.ser_out), 32'(stall_out[c]));
            chk($sformatf("T4_sv_c%0d", c + 1), 32'(if_msb.ser_valid), 32'd1);
            chk($sformatf("T4_fe_c%0d", c + 1), 32'(if_msb.frame_end), 32'(c == 5));
            tick();
        end
        if_msb.shift_en = 1'b1;
        chk("T4_idle_sv", 32'(if_msb.ser_valid), 32'd0);
        chk("T4_sipo", 32'(sipo_reg), 32'h9);
        $display("T4: word 1001 sent with 2-cycle stall on bit 1");

        // T5 back-to-back words, load_valid held throughout
        b2b_bits = 8'b1010_0101;
        if_msb.load_valid = 1'b1;
        if_msb.load_data  = 4'hA;
        if_msb.shift_en   = 1'b1;
        tick();
        if_msb.load_data = 4'h5;
        chk("T5_ready_mid", 32'(if_msb.load_ready), 32'd0);
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("T5_bit_c%0d", c + 1), 32'(if_msb.ser_out), 32'(b2b_bits[7-c]));
            chk($sformatf("T5_sv_c%0d", c + 1), 32'(if_msb.ser_valid), 32'd1);
            chk($sformatf("T5_fs_c%0d", c + 1), 32'(if_msb.frame_start), 32'((c == 0) || (c == 4)));
            tick();
            if (c == 3) begin
                if_msb.load_valid = 1'b0;
            end
        end
        chk("T5_idle_sv", 32'(if_msb.ser_valid), 32'd0);
        $display("T5: words A and 5 sent back to back");

        // T6 reset during bit 2 of 4'hF, then a clean word
        if_msb.load_valid = 1'b1;
        if_msb.load_data  = 4'hF;
        tick();
        if_msb.load_valid = 1'b0;
        tick();
        tick();
        chk("T6_bit2_before", 32'(if_msb.ser_out), 32'd1);
        clr = 1'b0;
        #1;
        chk("T6_ready_in_rst", 32'(if_msb.load_ready), 32'd0);
        tick();
        chk("T6_abort_sv", 32'(if_msb.ser_valid), 32'd0);
        chk("T6_abort_so", 32'(if_msb.ser_out), 32'd0);
        clr = 1'b1;
        tick();
        chk("T6_after_sv", 32'(if_msb.ser_valid), 32'd0);
        $display("T6: frame of F aborted by reset");
        run_frame("T6b", 4'b0110);

        // T7 LSB-first instance
        lsb_word = 4'b0001;
        if_lsb.load_valid = 1'b1;
        if_lsb.load_data  = lsb_word;
        if_lsb.shift_en   = 1'b1;
        tick();
        if_lsb.load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("T7_bit%0d", i), 32'(if_lsb.ser_out), 32'(lsb_word[i]));
            chk($sformatf("T7_fe%0d", i), 32'(if_lsb.frame_end), 32'(i == 3));
            tick();
        end
        chk("T7_idle_sv", 32'(if_lsb.ser_valid), 32'd0);
        $display("T7: word 0001 sent LSB first");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
